// File: rtl/fib_bcd.sv
// fib_bcd: converts a 10-bit binary value from the upstream Fibonacci stage into
// BCD with a 10-step double-dabble, then streams the digits most significant first.
// Optional build macro FIB_BCD_LZS_EN: when defined, leading zero digits are
// suppressed (a value of 0 still emits a single 0 digit).
//
// Output handshake: a digit transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the digit and out_last
// hold steady, and out_valid never drops until the transfer happens.
module fib_bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  input  logic [9:0] f,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_last,
  output logic       busy,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [25:0] shift_q;     // {thousands, hundreds, tens, units, binary}
  logic [3:0]  iter_q;
  logic [1:0]  idx_q;
  logic        out_valid_q;
  logic [3:0]  out_digit_q;
  logic        out_last_q;
  logic        overrun_q;

  logic [25:0] adj_d;
  logic [25:0] dabble_d;
  logic [1:0]  start_idx_d;
  logic [1:0]  idx_dec_d;

  function automatic logic [3:0] nib(input logic [15:0] bcd, input logic [1:0] i);
    return bcd[{i, 2'b00} +: 4];
  endfunction

  // One double-dabble step on the current register, plus the first digit index
  // to present if this step is the last one.
  always_comb begin
    adj_d = shift_q;
    for (int n = 0; n < 4; n++) begin
      if (shift_q[10 + 4*n +: 4] >= 4'd5)
        adj_d[10 + 4*n +: 4] = shift_q[10 + 4*n +: 4] + 4'd3;
    end
    dabble_d  = adj_d << 1;
    idx_dec_d = idx_q - 2'd1;
`ifdef FIB_BCD_LZS_EN
    if (dabble_d[25:22] != 4'd0)      start_idx_d = 2'd3;
    else if (dabble_d[21:18] != 4'd0) start_idx_d = 2'd2;
    else if (dabble_d[17:14] != 4'd0) start_idx_d = 2'd1;
    else                              start_idx_d = 2'd0;
`else
    start_idx_d = 2'd3;
`endif
  end

  // Control FSM with registered digit outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      iter_q      <= '0;
      idx_q       <= 2'd3;
      out_valid_q <= 1'b0;
      out_digit_q <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (done) begin
            shift_q <= {16'b0, f};
            iter_q  <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          if (done) overrun_q <= 1'b1;
          shift_q <= dabble_d;
          iter_q  <= iter_q + 4'd1;
          if (iter_q == 4'd9) begin
            state_q     <= EMIT;
            idx_q       <= start_idx_d;
            out_valid_q <= 1'b1;
            out_digit_q <= nib(dabble_d[25:10], start_idx_d);
            out_last_q  <= (start_idx_d == 2'd0);
          end
        end
        EMIT: begin
          if (out_ready && idx_q == 2'd0) begin
            // Final transfer; a coincident done starts the next value at once.
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_last_q  <= 1'b0;
            idx_q       <= 2'd3;
            if (done) begin
              shift_q <= {16'b0, f};
              iter_q  <= '0;
              state_q <= CONV;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            if (done) overrun_q <= 1'b1;
            if (out_ready) begin
              idx_q       <= idx_dec_d;
              out_digit_q <= nib(shift_q[25:10], idx_dec_d);
              out_last_q  <= (idx_dec_d == 2'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_digit = out_digit_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_bcd.sv
// tb_fib_bcd: table-driven and randomized bench for fib_bcd, with a decimal
// arithmetic reference model. Honors FIB_BCD_LZS_EN for expected digit lists.
module tb_fib_bcd;

  logic       clk = 1'b0;
  logic       rst, done, out_ready;
  logic [9:0] f;
  logic       out_valid, out_last, busy, overrun;
  logic [3:0] out_digit;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [9:0]  f;
    logic [15:0] bcd;
    int          mode;   // 0: always ready, 1: random ready, 2: stall 5 cycles first
  } vec_t;
  vec_t vecs[6];

  fib_bcd dut (
    .clk(clk), .rst(rst), .done(done), .f(f), .out_ready(out_ready),
    .out_valid(out_valid), .out_digit(out_digit), .out_last(out_last),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp_v);
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void push_expected(input logic [15:0] bcd);
    bit started;
    logic [3:0] d;
    started = 1'b0;
    exp_q.delete();
    for (int i = 3; i >= 0; i--) begin
      d = bcd[i*4 +: 4];
`ifdef FIB_BCD_LZS_EN
      if (d != 4'd0 || i == 0) started = 1'b1;
`else
      started = 1'b1;
`endif
      if (started) exp_q.push_back(d);
    end
  endfunction

  // called at a negedge: the next rising edge samples done
  task automatic send_done(input logic [9:0] v);
    done = 1'b1;
    f    = v;
  endtask

  // Waits for the first digit (latency check), then drains all digits.
  // k0: negedge count already elapsed since done; ovr_k: negedge on which to
  // pulse a stray done (0 = none); chain: pulse done with cf on final transfer.
  task automatic run_xfer(input logic [15:0] bcd, input int mode, input int k0,
                          input int ovr_k, input bit chain, input logic [9:0] cf);
    int lat, budget, hold;
    bit got_last, r, prev_hold;
    logic [3:0] prev_digit, e;
    logic prev_last;
    lat = -1;
    for (int k = k0; k <= 11; k++) begin
      @(negedge clk);
      if (k == ovr_k) begin
        done = 1'b1;
        f    = cf;
      end else begin
        done = 1'b0;
        f    = 10'($urandom_range(0, 1023));
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    done = 1'b0;
    chk("latency", lat, 11);
    push_expected(bcd);
    got_last = 1'b0; prev_hold = 1'b0; hold = 0; budget = 200;
    prev_digit = '0; prev_last = 1'b0;
    while (!got_last && budget > 0) begin
      budget--;
      if (!out_valid) begin
        chk("valid_in_emit", out_valid, 1);
        break;
      end
      if (prev_hold) begin
        chk("hold_digit", out_digit, prev_digit);
        chk("hold_last", out_last, prev_last);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = (hold >= 5);
      endcase
      hold++;
      out_ready = r;
      if (r) begin
        if (exp_q.size() == 0) begin
          chk("extra_digit", 1, 0);
          got_last = 1'b1;
        end else begin
          e = exp_q.pop_front();
          chk("digit", out_digit, e);
          chk("last", out_last, exp_q.size() == 0);
          if (exp_q.size() == 0) got_last = 1'b1;
        end
        if (got_last && chain) send_done(cf);
      end
      prev_hold  = !r;
      prev_digit = out_digit;
      prev_last  = out_last;
      @(negedge clk);
    end
    chk("digits_complete", got_last, 1);
    out_ready = 1'b0;
    done      = 1'b0;
    if (chain) chk("busy_chain", busy, 1);
    else begin
      chk("busy_after", busy, 0);
      chk("valid_after", out_valid, 0);
    end
  endtask

  initial begin
    int v, lat, nvalid;
    vecs[0] = '{10'd89,   16'h0089, 0};
    vecs[1] = '{10'd1023, 16'h1023, 0};
    vecs[2] = '{10'd0,    16'h0000, 0};
    vecs[3] = '{10'd55,   16'h0055, 2};
    vecs[4] = '{10'd999,  16'h0999, 1};
    vecs[5] = '{10'd100,  16'h0100, 1};

    // reset
    rst = 1'b1; done = 1'b0; f = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_digit", out_digit, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // table vectors
    foreach (vecs[i]) begin
      send_done(vecs[i].f);
      run_xfer(vecs[i].bcd, vecs[i].mode, 1, 0, 1'b0, 10'd0);
      @(negedge clk);
    end

    // random values against the decimal model
    for (int n = 0; n < 25; n++) begin
      v = $urandom_range(0, 1023);
      send_done(10'(v));
      run_xfer(ref_bcd(v), 1, 1, 0, 1'b0, 10'd0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    chk("no_overrun_yet", overrun, 0);

    // stray done during CONV: flagged, value in flight unaffected
    send_done(10'd13);
    run_xfer(ref_bcd(13), 0, 1, 3, 1'b0, 10'd21);
    chk("overrun_set", overrun, 1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", overrun, 1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("overrun_cleared", overrun, 0);
    @(negedge clk);

    // done coincident with final transfer: no overrun, next value follows
    send_done(10'd13);
    run_xfer(ref_bcd(13), 0, 1, 0, 1'b1, 10'd21);
    run_xfer(ref_bcd(21), 0, 2, 0, 1'b0, 10'd0);
    chk("chain_no_overrun", overrun, 0);
    @(negedge clk);

    // reset during EMIT after first digit
    send_done(10'd300);
    @(negedge clk); done = 1'b0;
    @(negedge clk); send_done(10'd5);
    @(negedge clk); done = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_emit_valid_seen", out_valid, 1);
    chk("rst_emit_overrun", overrun, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_emit_valid", out_valid, 0);
    chk("rst_emit_busy", busy, 0);
    chk("rst_emit_overrun_clr", overrun, 0);
    chk("rst_emit_digit", out_digit, 0);
    out_ready = 1'b1;
    nvalid = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("rst_emit_no_digits", nvalid, 0);
    out_ready = 1'b0;

    // done together with reset is not captured
    rst = 1'b1; send_done(10'd77);
    @(negedge clk);
    rst = 1'b0; done = 1'b0;
    chk("rst_done_busy", busy, 0);
    repeat (12) @(negedge clk);
    chk("rst_done_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_bcd.md
FIB_BCD -- requirements
Module: fib_bcd

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 done  input  1  one-cycle strobe from the upstream Fibonacci stage; f is valid while done=1.
REQ-004 f  input  10  binary result from upstream, range 0..1023.
REQ-005 out_ready  input  1  downstream accepts out_digit when out_valid=1 and out_ready=1.
REQ-006 out_valid  output  1  out_digit/out_last hold a digit to transfer.
REQ-007 out_digit  output  4  BCD digit, most significant first.
REQ-008 out_last  output  1  high with the final digit of a value (units digit).
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 overrun  output  1  sticky flag: a done strobe was dropped.

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, CONV, EMIT.
REQ-012 IDLE, done=1: SHALL capture f into a 26-bit shift register {16'b0, f}, clear the iteration count, and enter CONV.
REQ-013 CONV: SHALL run exactly 10 double-dabble iterations, one per clock; each adds 3 to every BCD nibble >= 5, then shifts left 1.
REQ-014 CONV, 10th iteration edge: SHALL enter EMIT with digit index 3 (thousands).
REQ-015 Latency: out_valid SHALL first assert 11 cycles after the cycle in which done was sampled.
REQ-016 EMIT: out_valid=1; out_digit = BCD nibble at the current index; out_last=1 iff index=0.
REQ-017 out_digit and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 On handshake (out_valid & out_ready): index decrements; on the handshake with index=0, state SHALL return to IDLE.
REQ-019 out_valid, out_digit, out_last SHALL be 0 outside EMIT.
REQ-020 done=1 in CONV or EMIT SHALL be ignored and set overrun=1; the value in flight is unaffected.
REQ-021 Exception to REQ-020: done=1 in the same cycle as the final handshake (index 0) SHALL capture f and enter CONV directly, with no overrun.
REQ-022 overrun SHALL stay set until reset.
REQ-023 Input 1023 SHALL produce digits 1,0,2,3; no value exceeds 4 digits.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, index=3, iteration count=0, shift register=0, out_valid=0, out_digit=0, out_last=0, busy=0, overrun=0.
REQ-025 Reset SHALL take priority over done and any handshake, including mid-CONV or mid-EMIT; the partial value is discarded and no further digits are emitted.
REQ-026 done arriving with rst=1 SHALL NOT be captured.

Configuration
REQ-027 Macro FIB_BCD_LZS_EN SHALL select leading-zero suppression.
REQ-028 Defined: on entering EMIT, the index SHALL start at the most significant nonzero digit (index 0 if the value is 0); exactly one digit, 0, is emitted for input 0.
REQ-029 Undefined: EMIT SHALL always start at index 3 and emit four digits, leading zeros included.
REQ-030 Latency (REQ-015) SHALL be identical in both builds.

Verification
REQ-031 f=89, done pulse, out_ready=1 -> out_valid after 11 cycles; digits 0,0,8,9 with out_last on 9 (LZS_EN: 8,9).
REQ-032 f=1023 -> digits 1,0,2,3 on consecutive cycles; busy=0 on the cycle after the last handshake.
REQ-033 f=0 -> 0,0,0,0 (LZS_EN: single 0 with out_last=1).
REQ-034 f=55, out_ready low 5 cycles at first digit -> out_digit held at 0, out_valid held at 1; then 0,0,5,5 (LZS_EN: held at 5; then 5,5).
REQ-035 f=13, second done (f=21) during CONV -> overrun=1; output digits are 0,0,1,3 only. Done with f=21 coincident with the final handshake -> no overrun, then 0,0,2,1.
REQ-036 rst during EMIT after first digit -> out_valid=0 and busy=0 next cycle; overrun cleared; no remaining digits emitted.
